load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU: takes the ALU result as effective address plus rs2 store data and drives a simple req/ack data bus to data RAM and the UART register window.
- Produces the word-lane byte enables and store data, and extracts and extends the load result for register writeback.
- Stalls the single-cycle core while a bus transfer is outstanding.
- Flags misaligned/illegal accesses and bus timeouts.

Parameters:
- WIDTH, 32, data/address width (byte lanes = WIDTH/8; only 32 supported).
- TIMEOUT, 255, max BUS-state cycles without bus_ack before an access fault; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  current instruction is a load/store
- mem_write  in  1  1=store, 0=load
- funct3  in  3  RISC-V funct3 access size/sign
- addr  in  WIDTH  effective address (ALU OUT)
- wdata  in  WIDTH  store data (rs2)
- stall  out  1  hold PC/regfile this cycle
- done  out  1  one-cycle pulse: access finished; load_data valid
- load_data  out  WIDTH  extended load result
- fault_misaligned  out  1  one-cycle pulse: misaligned or illegal funct3
- fault_access  out  1  one-cycle pulse: bus timeout
- bus_req  out  1  transfer request
- bus_we  out  1  write strobe
- bus_addr  out  WIDTH  word-aligned address (addr[1:0]=00)
- bus_be  out  4  byte enables
- bus_wdata  out  WIDTH  lane-shifted store data
- bus_rdata  in  WIDTH  read data, valid with bus_ack
- bus_ack  in  1  transfer complete

Behaviour:
- Reset (async, immediate): state IDLE; bus_req, bus_we, done, both faults = 0; bus_addr, bus_be, bus_wdata, load_data = 0; timeout counter = 0.
- States: IDLE, BUS, RESP, FAULT.
- IDLE:
  - stall = mem_valid (combinational).
  - Legal and aligned request -> capture bus_addr/bus_be/bus_wdata/bus_we/funct3/addr[1:0] in registers, go to BUS.
  - Illegal or misaligned request -> FAULT.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
  - Loads drive the same be pattern.
- Store data: byte replicated to all 4 lanes, half replicated to both halves, word unchanged. Lanes not enabled are don't-care but must be the replicated value.
- BUS:
  - bus_req = 1 and stall = 1; bus outputs stable for the whole state.
  - Counter increments each cycle.
  - bus_ack -> latch the extracted load_data (loads only), go to RESP.
  - Counter reaches TIMEOUT without ack (TIMEOUT != 0) -> FAULT with access cause.
  - Ack on the expiry cycle: ack wins.
- RESP: stall = 0, done = 1 for one cycle; return to IDLE; counter cleared.
- FAULT:
  - stall = 0; exactly one of fault_misaligned/fault_access = 1 for one cycle; done = 0; no bus_req was issued for misaligned.
  - Return to IDLE.
- Load extraction: select lane by the latched addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. load_data holds its value until the next ack.
- Latency: minimum 3 cycles per access (IDLE, BUS with same-cycle ack, RESP). N wait cycles add N.
- bus_ack outside BUS is ignored.
- mem_valid dropping while in BUS does not abort the transfer; it completes normally.
- Stores ignore bus_rdata.
- Reset mid-BUS: bus_req drops asynchronously, and no done or fault is pulsed.

Decomposition:
- Shared package/header (also used by the decoder):
  - funct3 load/store encodings (LB..LHU, SB..SW).
  - FSM state encodings.
  - Byte-enable constants.
- One natural sub-module: lsu_data_align, combinational. It covers store lane replication/be generation and load lane select/extension, and is reusable by a future DMA path.

Test Plan:
- LB, addr=0x00000103, bus_rdata=0x80FF0000, ack first BUS cycle -> bus_addr=0x00000100, bus_be=1000, done on cycle 3, load_data=0xFFFFFF80; LBU same -> 0x00000080.
- SH, addr=0x00000202, wdata=0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, stall high 2 cycles, done pulse, no fault.
- LW, addr=0x00000002 -> no bus_req ever, stall=1 then fault_misaligned=1 for 1 cycle, done=0; funct3=011 at aligned addr -> same fault response.
- TIMEOUT=4, LW with bus_ack never asserted -> bus_req high 4 cycles, then fault_access=1 for 1 cycle, back to IDLE; repeat with ack on the 4th BUS cycle -> done, no fault.
- LHU, addr=0x2, ack after 5 wait cycles, bus_rdata=0xBEEF0000 -> bus outputs stable throughout, load_data=0x0000BEEF, total 8 stall/done cycles.
- Assert rst during BUS -> bus_req low immediately (before next edge), all outputs zero, next access behaves normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store path: funct3 access codes, access sizes,
// byte-enable patterns and the LSU state machine encoding.
package load_store_unit_pkg;

   // funct3 encodings (loads and stores share the low three codes)
   localparam logic [2:0] F3_BYTE   = 3'b000;  // LB / SB
   localparam logic [2:0] F3_HALF   = 3'b001;  // LH / SH
   localparam logic [2:0] F3_WORD   = 3'b010;  // LW / SW
   localparam logic [2:0] F3_BYTE_U = 3'b100;  // LBU
   localparam logic [2:0] F3_HALF_U = 3'b101;  // LHU

   // Access size carried in funct3[1:0]
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Byte-enable patterns before shifting into the addressed lane
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUS   = 2'd1,
      ST_RESP  = 2'd2,
      ST_FAULT = 2'd3
   } lsu_state_t;

   // Stores only have the signed-size codes; loads add the unsigned variants.
   function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_BYTE) || (f3 == F3_HALF) || (f3 == F3_WORD);
      if (!write) ok = ok || (f3 == F3_BYTE_U) || (f3 == F3_HALF_U);
      return ok;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: request legality/alignment, byte enables and store
// lane replication on the request side; lane select and extension on the
// response side. The two sides have separate inputs so the response side can
// use the request fields latched when the transfer started.
module lsu_data_align
   import load_store_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             write,
   input  logic [2:0]       req_funct3,
   input  logic [1:0]       req_offset,
   input  logic [WIDTH-1:0] wdata,
   input  logic [2:0]       rsp_funct3,
   input  logic [1:0]       rsp_offset,
   input  logic [WIDTH-1:0] rdata,
   output logic             legal,
   output logic             aligned,
   output logic [3:0]       be,
   output logic [WIDTH-1:0] store_data,
   output logic [WIDTH-1:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Request side: legality, alignment, lane enables and replicated store data
   always_comb begin
      legal      = funct3_legal(write, req_funct3);
      aligned    = 1'b0;
      be         = BE_WORD;
      store_data = wdata;
      case (req_funct3[1:0])
         SIZE_BYTE: begin
            aligned    = 1'b1;
            be         = BE_BYTE << req_offset;
            store_data = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            aligned    = ~req_offset[0];
            be         = BE_HALF << req_offset;
            store_data = {2{wdata[15:0]}};
         end
         SIZE_WORD: begin
            aligned    = (req_offset == 2'b00);
         end
         default: begin
            aligned    = 1'b0;
         end
      endcase
   end

   // Response side: pick the addressed lane and sign- or zero-extend it
   always_comb begin
      byte_sel  = rdata[{rsp_offset, 3'b000} +: 8];
      half_sel  = rsp_offset[1] ? rdata[31:16] : rdata[15:0];
      load_data = rdata;
      case (rsp_funct3[1:0])
         SIZE_BYTE: load_data = rsp_funct3[2] ? {{(WIDTH-8){1'b0}}, byte_sel}
                                              : {{(WIDTH-8){byte_sel[7]}}, byte_sel};
         SIZE_HALF: load_data = rsp_funct3[2] ? {{(WIDTH-16){1'b0}}, half_sel}
                                              : {{(WIDTH-16){half_sel[15]}}, half_sel};
         default:   load_data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns an ALU effective address plus rs2 into a single
// req/ack bus transfer, stalls the core while it is outstanding, and returns
// the extended load result. Misaligned/illegal requests and bus timeouts are
// reported as one-cycle fault pulses. Handshake: bus_req stays high with
// stable bus_addr/bus_be/bus_wdata/bus_we for the whole transfer and the
// transfer completes on the first cycle bus_ack is seen with bus_req high.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   input  logic             mem_write,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] load_data,
   output logic             fault_misaligned,
   output logic             fault_access,
   output logic             bus_req,
   output logic             bus_we,
   output logic [WIDTH-1:0] bus_addr,
   output logic [3:0]       bus_be,
   output logic [WIDTH-1:0] bus_wdata,
   input  logic [WIDTH-1:0] bus_rdata,
   input  logic             bus_ack
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   lsu_state_t       state, state_next;
   logic [CW-1:0]    count;
   logic [2:0]       funct3_q;
   logic [1:0]       offset_q;
   logic             cause_access;
   logic             legal, aligned, expired;
   logic [3:0]       be_next;
   logic [WIDTH-1:0] store_data, extracted;

   lsu_data_align #(.WIDTH(WIDTH)) u_align (
      .write      (mem_write),
      .req_funct3 (funct3),
      .req_offset (addr[1:0]),
      .wdata      (wdata),
      .rsp_funct3 (funct3_q),
      .rsp_offset (offset_q),
      .rdata      (bus_rdata),
      .legal      (legal),
      .aligned    (aligned),
      .be         (be_next),
      .store_data (store_data),
      .load_data  (extracted)
   );

   // The count holds the number of BUS cycles already spent, so expiry is
   // flagged on the TIMEOUT-th BUS cycle; an ack in that cycle still wins.
   assign expired = (TIMEOUT != 0) && (count == CW'(TIMEOUT - 1));

   // Status pulses decode straight from state so reset clears them at once
   assign bus_req          = (state == ST_BUS);
   assign done             = (state == ST_RESP);
   assign fault_misaligned = (state == ST_FAULT) && !cause_access;
   assign fault_access     = (state == ST_FAULT) &&  cause_access;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state and stall decode
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      case (state)
         ST_IDLE: begin
            stall = mem_valid;
            if (mem_valid) state_next = (legal && aligned) ? ST_BUS : ST_FAULT;
         end
         ST_BUS: begin
            stall = 1'b1;
            if (bus_ack)      state_next = ST_RESP;
            else if (expired) state_next = ST_FAULT;
         end
         ST_RESP:  state_next = ST_IDLE;
         ST_FAULT: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Capture the request, time the bus phase and latch load results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_addr     <= '0;
         bus_be       <= '0;
         bus_wdata    <= '0;
         bus_we       <= 1'b0;
         funct3_q     <= '0;
         offset_q     <= '0;
         load_data    <= '0;
         count        <= '0;
         cause_access <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               count        <= '0;
               cause_access <= 1'b0;
               if (mem_valid && legal && aligned) begin
                  bus_addr  <= {addr[WIDTH-1:2], 2'b00};
                  bus_be    <= be_next;
                  bus_wdata <= store_data;
                  bus_we    <= mem_write;
                  funct3_q  <= funct3;
                  offset_q  <= addr[1:0];
               end
            end
            ST_BUS: begin
               count <= count + 1'b1;
               if (bus_ack) begin
                  if (!bus_we) load_data <= extracted;
               end else if (expired) begin
                  cause_access <= 1'b1;
               end
            end
            default: count <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a default-timeout instance (a) and a TIMEOUT=4
// instance (b) share the request/bus inputs but have their own mem_valid.
module tb_load_store_unit;

   typedef struct {
      logic        sel;         // 0: instance a, 1: instance b
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;       // BUS cycles before ack; -1 = never ack
      logic [31:0] exp_baddr;
      logic [3:0]  exp_be;
      logic [31:0] exp_bwdata;
      logic [31:0] exp_load;
      logic [2:0]  exp_end;     // {done, fault_misaligned, fault_access}
      int          exp_cycles;  // IDLE cycle through the done/fault cycle
      int          exp_bus;     // cycles with bus_req high
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid_a = 1'b0, mem_valid_b = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
   logic        bus_ack = 1'b0;
   logic        sel = 1'b0;

   logic        stall_a, done_a, fmis_a, facc_a, req_a, we_a;
   logic [31:0] ld_a, baddr_a, bwdata_a;
   logic [3:0]  be_a;
   logic        stall_b, done_b, fmis_b, facc_b, req_b, we_b;
   logic [31:0] ld_b, baddr_b, bwdata_b;
   logic [3:0]  be_b;

   logic        s_stall, s_done, s_fmis, s_facc, s_req, s_we;
   logic [31:0] s_ld, s_baddr, s_bwdata;
   logic [3:0]  s_be;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_load[2];
   vec_t        tbl[16];

   load_store_unit #(.WIDTH(32), .TIMEOUT(255)) dut_a (
      .clk(clk), .rst(rst), .mem_valid(mem_valid_a), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall_a), .done(done_a),
      .load_data(ld_a), .fault_misaligned(fmis_a), .fault_access(facc_a),
      .bus_req(req_a), .bus_we(we_a), .bus_addr(baddr_a), .bus_be(be_a),
      .bus_wdata(bwdata_a), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst), .mem_valid(mem_valid_b), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall_b), .done(done_b),
      .load_data(ld_b), .fault_misaligned(fmis_b), .fault_access(facc_b),
      .bus_req(req_b), .bus_we(we_b), .bus_addr(baddr_b), .bus_be(be_b),
      .bus_wdata(bwdata_b), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   assign s_stall  = sel ? stall_b  : stall_a;
   assign s_done   = sel ? done_b   : done_a;
   assign s_fmis   = sel ? fmis_b   : fmis_a;
   assign s_facc   = sel ? facc_b   : facc_a;
   assign s_req    = sel ? req_b    : req_a;
   assign s_we     = sel ? we_b     : we_a;
   assign s_ld     = sel ? ld_b     : ld_a;
   assign s_baddr  = sel ? baddr_b  : baddr_a;
   assign s_bwdata = sel ? bwdata_b : bwdata_a;
   assign s_be     = sel ? be_b     : be_a;

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                               input int waits, input logic [31:0] baddr, input logic [3:0] be,
                               input logic [31:0] bwd, input logic [31:0] ld, input logic [2:0] e,
                               input int cyc, input int nbus);
      vec_t v;
      v.sel = s; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.waits = waits;
      v.exp_baddr = baddr; v.exp_be = be; v.exp_bwdata = bwd; v.exp_load = ld;
      v.exp_end = e; v.exp_cycles = cyc; v.exp_bus = nbus;
      return v;
   endfunction

   // Byte-level reference model for a legal, aligned access on instance a
   function automatic vec_t model_vec(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [31:0] rd, input int waits);
      vec_t v;
      int   n, lo;
      v = mk(1'b0, we, f3, a, wd, rd, waits, a & 32'hFFFF_FFFC, 4'b0000, '0, '0, 3'b100,
             waits + 3, waits + 1);
      n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      lo = int'(a[1:0]);
      for (int i = 0; i < 4; i++) begin
         v.exp_be[i] = (i >= lo) && (i < lo + n);
         v.exp_bwdata[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      for (int i = 0; i < n; i++) v.exp_load[8*i +: 8] = rd[8*(lo + i) +: 8];
      if (!f3[2] && n < 4 && v.exp_load[8*n - 1])
         for (int i = n; i < 4; i++) v.exp_load[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   // Driver + monitor for one access; entered and left just after a posedge
   task automatic run_vec(input vec_t v, input string tag);
      int          cyc, bus_cyc;
      logic        stall_ok, bus_ok, fin;
      logic [2:0]  end_flags;
      logic [31:0] exp;
      sel = v.sel; mem_write = v.we; funct3 = v.f3; addr = v.addr;
      wdata = v.wdata; bus_rdata = v.rdata; bus_ack = 1'b0;
      if (v.sel) mem_valid_b = 1'b1; else mem_valid_a = 1'b1;
      exp = (v.exp_end == 3'b100 && !v.we) ? v.exp_load : last_load[v.sel];
      exp_q.push_back(exp);
      last_load[v.sel] = exp;
      cyc = 0; bus_cyc = 0; stall_ok = 1'b1; bus_ok = 1'b1; fin = 1'b0; end_flags = 3'b000;
      while (!fin && cyc < 40) begin
         if (s_req) begin
            bus_cyc++;
            bus_ack = (v.waits >= 0) && (bus_cyc == v.waits + 1);
            if (s_baddr !== v.exp_baddr || s_be !== v.exp_be || s_we !== v.we ||
                (v.we && s_bwdata !== v.exp_bwdata)) bus_ok = 1'b0;
         end else begin
            bus_ack = 1'b0;
         end
         @(negedge clk);
         cyc++;
         end_flags = {s_done, s_fmis, s_facc};
         if (end_flags != 3'b000) begin
            fin = 1'b1;
            if (s_stall) stall_ok = 1'b0;
         end else if (!s_stall) begin
            stall_ok = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus_ack = 1'b0; mem_valid_a = 1'b0; mem_valid_b = 1'b0;
      check({tag, "_end"}, 32'(end_flags), 32'(v.exp_end));
      check({tag, "_cycles"}, 32'(cyc), 32'(v.exp_cycles));
      check({tag, "_bus_cycles"}, 32'(bus_cyc), 32'(v.exp_bus));
      check({tag, "_stall"}, 32'(stall_ok), 32'd1);
      if (v.exp_bus > 0) check({tag, "_bus_fields"}, 32'(bus_ok), 32'd1);
      check({tag, "_load_data"}, s_ld, exp_q.pop_front());
   endtask

   initial begin
      logic [2:0]  f3_ld[5];
      logic [2:0]  f3;
      logic [31:0] a;
      logic        we, pulse;
      vec_t        v;
      f3_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      last_load[0] = '0;
      last_load[1] = '0;

      //                 sel we  f3      addr        wdata          rdata        w   baddr      be       bwdata         load           end     cyc bus
      tbl[0]  = mk(1'b0, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 3'b100, 3, 1);
      tbl[1]  = mk(1'b0, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080, 3'b100, 3, 1);
      tbl[2]  = mk(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0,        3'b100, 3, 1);
      tbl[3]  = mk(1'b0, 1'b0, 3'b010, 32'h002, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        3'b010, 2, 0);
      tbl[4]  = mk(1'b0, 1'b0, 3'b011, 32'h004, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        3'b010, 2, 0);
      tbl[5]  = mk(1'b0, 1'b0, 3'b101, 32'h002, 32'h0,        32'hBEEF0000, 5, 32'h0,   4'b1100, 32'h0,        32'h0000BEEF, 3'b100, 8, 6);
      tbl[6]  = mk(1'b0, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        1, 32'h10,  4'b1111, 32'hDEADBEEF, 32'h0,        3'b100, 4, 2);
      tbl[7]  = mk(1'b0, 1'b0, 3'b001, 32'h000, 32'h0,        32'h00008001, 0, 32'h0,   4'b0011, 32'h0,        32'hFFFF8001, 3'b100, 3, 1);
      tbl[8]  = mk(1'b0, 1'b1, 3'b000, 32'h031, 32'h000000A5, 32'h0,        2, 32'h30,  4'b0010, 32'hA5A5A5A5, 32'h0,        3'b100, 5, 3);
      tbl[9]  = mk(1'b0, 1'b1, 3'b100, 32'h000, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        3'b010, 2, 0);
      tbl[10] = mk(1'b0, 1'b1, 3'b001, 32'h001, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        3'b010, 2, 0);
      tbl[11] = mk(1'b0, 1'b0, 3'b000, 32'h002, 32'h0,        32'h007F0000, 0, 32'h0,   4'b0100, 32'h0,        32'h0000007F, 3'b100, 3, 1);
      tbl[12] = mk(1'b0, 1'b0, 3'b001, 32'h006, 32'h0,        32'h7FFF1234, 0, 32'h4,   4'b1100, 32'h0,        32'h00007FFF, 3'b100, 3, 1);
      tbl[13] = mk(1'b0, 1'b0, 3'b100, 32'h021, 32'h0,        32'h0000C300, 0, 32'h20,  4'b0010, 32'h0,        32'h000000C3, 3'b100, 3, 1);
      tbl[14] = mk(1'b1, 1'b0, 3'b010, 32'h008, 32'h0,        32'h0,       -1, 32'h8,   4'b1111, 32'h0,        32'h0,        3'b001, 6, 4);
      tbl[15] = mk(1'b1, 1'b0, 3'b010, 32'h008, 32'h0,        32'h11223344, 3, 32'h8,   4'b1111, 32'h0,        32'h11223344, 3'b100, 6, 4);

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_status_a", 32'({stall_a, done_a, fmis_a, facc_a, req_a, we_a}), 32'd0);
      check("reset_bus_a", baddr_a | bwdata_a | 32'(be_a), 32'd0);
      check("reset_load_a", ld_a, 32'd0);
      check("reset_status_b", 32'({stall_b, done_b, fmis_b, facc_b, req_b, we_b}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Random legal, aligned accesses against the byte-level model
      for (int i = 0; i < 16; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = we ? f3_ld[$urandom_range(0, 2)] : f3_ld[$urandom_range(0, 4)];
         a  = $urandom() & 32'hFFFF_FFFC;
         if (f3[1:0] == 2'b00)      a[1:0] = 2'($urandom_range(0, 3));
         else if (f3[1:0] == 2'b01) a[1]   = 1'($urandom_range(0, 1));
         v = model_vec(we, f3, a, $urandom(), $urandom(), $urandom_range(0, 3));
         run_vec(v, $sformatf("rnd%0d", i));
      end

      // Reset while a transfer is outstanding
      sel = 1'b0; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40; bus_ack = 1'b0;
      mem_valid_a = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_pre_req", 32'(req_a), 32'd1);
      #2;
      rst = 1'b1;
      mem_valid_a = 1'b0;
      #1;
      check("rst_mid_req_async", 32'(req_a), 32'd0);
      check("rst_mid_status", 32'({stall_a, done_a, fmis_a, facc_a, we_a}), 32'd0);
      check("rst_mid_bus", baddr_a | bwdata_a | 32'(be_a) | ld_a, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done_a || fmis_a || facc_a || req_a) pulse = 1'b1;
      end
      check("rst_mid_no_pulse", 32'(pulse), 32'd0);
      last_load[0] = '0;
      @(posedge clk); #1;
      run_vec(tbl[0], "post_rst_lb");
      run_vec(tbl[2], "post_rst_sh");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
